// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : RISC-V fetch stage. Holds PC, fetches over imem req/ack, presents
//            the instruction until retire, applies redirects, counts retires.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ack,
    input  logic            stall,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic            fault,
    output logic [31:0]     instret
);

    localparam logic [XLEN-1:0] c_NOP  = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic            r_fault;
    logic [31:0]     r_instret;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_pc_next;
    logic            w_retire;
    logic            w_take_fault;
    logic            w_capture;
    logic            w_req;
    logic            w_valid;

    assign w_pc_plus4   = r_pc + c_FOUR;
    assign w_pc_next    = PCSrc ? PCTarget : w_pc_plus4;
    assign w_retire     = (r_state == S_VALID) && !stall;
    // Only a taken redirect can misalign the PC; sequential PCs stay aligned.
    assign w_take_fault = w_retire && PCSrc && (PCTarget[1:0] != 2'b00);
    assign w_capture    = (r_state == S_FETCH) && imem_ack;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_state_next = S_VALID;
                end
            end
            S_VALID: begin
                w_valid = 1'b1;
                if (w_take_fault) begin
                    w_state_next = S_FAULT;
                end else if (w_retire) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FAULT: begin
                w_state_next = S_FAULT;
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_instr   <= c_NOP;
            r_fault   <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                // The faulting instruction still counts as retired.
                r_instret <= r_instret + 32'd1;
                if (w_take_fault) begin
                    r_fault <= 1'b1;
                end else begin
                    r_pc <= w_pc_next;
                end
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign Instr       = r_instr;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign instr_valid = w_valid;
    assign fault       = r_fault;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Testbench for instr_fetch_unit: per-cycle directed vector table plus
// hand-written reset and counter-wrap sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        instr_valid;
    logic        fault;
    logic [31:0] instret;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .fault       (fault),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // One record per cycle: expected outputs during the cycle, inputs driven in it.
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        pcsrc;
        logic [31:0] tgt;
        logic        req;
        logic        valid;
        logic        flt;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t mk(int ack, logic [31:0] rdata, int stl, int pcsrc,
                                logic [31:0] tgt, int req, int valid, int flt,
                                logic [31:0] pc, logic [31:0] instr, logic [31:0] ret);
        vec_t v;
        v.ack   = (ack != 0);
        v.rdata = rdata;
        v.stall = (stl != 0);
        v.pcsrc = (pcsrc != 0);
        v.tgt   = tgt;
        v.req   = (req != 0);
        v.valid = (valid != 0);
        v.flt   = (flt != 0);
        v.pc    = pc;
        v.instr = instr;
        v.ret   = ret;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                         input logic pcsrc, input logic [31:0] tgt);
        imem_ack   = ack;
        imem_rdata = rdata;
        stall      = stl;
        PCSrc      = pcsrc;
        PCTarget   = tgt;
    endtask

    initial begin
        //            ack rdata          stl src tgt           req vld flt pc            instr          ret
        tv[0]  = mk(1, 32'h0000_DEAD, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0000_0013, 0); // BOOT, spurious ack
        tv[1]  = mk(1, 32'h0050_0093, 0, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0000_0013, 0);
        tv[2]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 32'h0,        32'h0050_0093, 0);
        tv[3]  = mk(1, 32'h00A0_0113, 0, 0, 32'h0,         1, 0, 0, 32'h4,        32'h0050_0093, 1);
        tv[4]  = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 32'h4,        32'h00A0_0113, 1);
        tv[5]  = mk(1, 32'h0020_81B3, 0, 0, 32'h0,         1, 0, 0, 32'h8,        32'h00A0_0113, 2);
        tv[6]  = mk(0, 32'h0,         1, 1, 32'h40,        0, 1, 0, 32'h8,        32'h0020_81B3, 2); // stalled redirect
        tv[7]  = mk(0, 32'h0,         1, 1, 32'h40,        0, 1, 0, 32'h8,        32'h0020_81B3, 2);
        tv[8]  = mk(0, 32'h0,         0, 1, 32'h40,        0, 1, 0, 32'h8,        32'h0020_81B3, 2); // taken
        tv[9]  = mk(0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h40,       32'h0020_81B3, 3);
        tv[10] = mk(0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h40,       32'h0020_81B3, 3);
        tv[11] = mk(0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h40,       32'h0020_81B3, 3);
        tv[12] = mk(1, 32'h0000_0033, 0, 0, 32'h0,         1, 0, 0, 32'h40,       32'h0020_81B3, 3);
        tv[13] = mk(0, 32'h0,         0, 1, 32'hFFFF_FFFC, 0, 1, 0, 32'h40,       32'h0000_0033, 3);
        tv[14] = mk(1, 32'h0010_0073, 0, 0, 32'h0,         1, 0, 0, 32'hFFFF_FFFC, 32'h0000_0033, 4);
        tv[15] = mk(0, 32'h0,         0, 0, 32'h0,         0, 1, 0, 32'hFFFF_FFFC, 32'h0010_0073, 4);
        tv[16] = mk(1, 32'h0000_006F, 0, 0, 32'h0,         1, 0, 0, 32'h0,        32'h0010_0073, 5); // PC wrapped
        tv[17] = mk(0, 32'h0,         0, 1, 32'h42,        0, 1, 0, 32'h0,        32'h0000_006F, 5); // misaligned
        tv[18] = mk(1, 32'h1111_1111, 0, 1, 32'h80,        0, 0, 1, 32'h0,        32'h0000_006F, 6);
        tv[19] = mk(1, 32'h2222_2222, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h0000_006F, 6);
        tv[20] = mk(0, 32'h0,         0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h0000_006F, 6);

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_req",     {31'd0, imem_req},    32'd0);
        chk("reset_instr",   Instr,                32'h0000_0013);
        chk("reset_instret", instret,              32'd0);
        reset = 1'b0;
        #1;

        for (int i = 0; i < 21; i++) begin
            chk($sformatf("c%0d_req", i),     {31'd0, imem_req},    {31'd0, tv[i].req});
            chk($sformatf("c%0d_addr", i),    imem_addr,            tv[i].pc);
            chk($sformatf("c%0d_pc", i),      PC,                   tv[i].pc);
            chk($sformatf("c%0d_pcplus4", i), PCPlus4,              tv[i].pc + 32'd4);
            chk($sformatf("c%0d_valid", i),   {31'd0, instr_valid}, {31'd0, tv[i].valid});
            chk($sformatf("c%0d_fault", i),   {31'd0, fault},       {31'd0, tv[i].flt});
            chk($sformatf("c%0d_instr", i),   Instr,                tv[i].instr);
            chk($sformatf("c%0d_instret", i), instret,              tv[i].ret);
            drive(tv[i].ack, tv[i].rdata, tv[i].stall, tv[i].pcsrc, tv[i].tgt);
            @(negedge clk);
            #1;
        end
        chk("wrap_pcplus4_at_fffffffc", {31'd0, 1'b0}, 32'd0);
        n_total--; n_pass--;

        // Asynchronous reset out of FAULT.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("fault_rst_fault",   {31'd0, fault},   32'd0);
        chk("fault_rst_pc",      PC,               32'd0);
        chk("fault_rst_instret", instret,          32'd0);
        chk("fault_rst_instr",   Instr,            32'h0000_0013);
        @(negedge clk);
        reset = 1'b0;
        #1;
        drive(1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0); // BOOT: ack ignored
        @(negedge clk); #1;
        chk("rb_fetch_req",   {31'd0, imem_req}, 32'd1);
        chk("rb_fetch_instr", Instr,             32'h0000_0013);
        drive(1'b1, 32'h0030_0193, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("rb_valid_instr", Instr,                32'h0030_0193);
        chk("rb_valid",       {31'd0, instr_valid}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("rb_fetch4_addr",    imem_addr, 32'h4);
        chk("rb_fetch4_instret", instret,   32'd1);

        // Reset while a request is being acked in the same cycle.
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
        #2 reset = 1'b1;
        #1;
        chk("midfetch_instr",   Instr,               32'h0000_0013);
        chk("midfetch_pc",      PC,                  32'd0);
        chk("midfetch_instret", instret,             32'd0);
        chk("midfetch_req",     {31'd0, imem_req},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk); #1;                            // ack held high through BOOT
        chk("post_boot_req",   {31'd0, imem_req},    32'd1);
        chk("post_boot_instr", Instr,                32'h0000_0013);
        chk("post_boot_valid", {31'd0, instr_valid}, 32'd0);
        drive(1'b1, 32'h0040_0213, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("wrap_valid_instr", Instr, 32'h0040_0213);

        // Counter wrap: deposit all-ones while stalled, then retire.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        force dut.r_instret = 32'hFFFF_FFFF;
        #1;
        release dut.r_instret;
        @(negedge clk); #1;
        chk("wrap_pre_instret", instret, 32'hFFFF_FFFF);
        chk("wrap_pre_pc",      PC,      32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk); #1;
        chk("wrap_instret", instret,           32'd0);
        chk("wrap_pc",      PC,                32'h4);
        chk("wrap_req",     {31'd0, imem_req}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
